// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 demultiplexer with four single-entry valid/ready slots.
// Optional sticky stall flag (ovf/ovf_clr) enabled by defining DEMUX1X4_OVF_EN.
module demux1x4_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
`ifdef DEMUX1X4_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  localparam int unsigned NSLOT = 4;

  logic [NSLOT-1:0][WIDTH-1:0] data_q, data_d;
  logic [NSLOT-1:0]            full_q, full_d;
  logic [NSLOT-1:0]            load_c;
  logic                        accept_c;

  // Selected slot can take a word if empty or being drained this edge.
  assign in_ready = ~full_q[ctrl] | out_ready[ctrl];
  assign accept_c = in_valid & in_ready;
  assign load_c   = accept_c ? NSLOT'(4'b0001 << ctrl) : '0;

  // Per-slot next state: a load wins over a drain on the same slot.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    for (int k = 0; k < NSLOT; k++) begin
      if (load_c[k]) begin
        data_d[k] = in_data;
        full_d[k] = 1'b1;
      end else if (full_q[k] && out_ready[k]) begin
        full_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= '0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign A         = data_q[0];
  assign B         = data_q[1];
  assign C         = data_q[2];
  assign D         = data_q[3];
  assign out_valid = full_q;

`ifdef DEMUX1X4_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky stall flag; a set on the same edge as a clear takes priority.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (in_valid && !in_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_demux1x4_reg.sv
// Self-checking bench for demux1x4_reg: directed scenarios plus random traffic
// against a slot-level behavioural model compared every falling edge.
module tb_demux1x4_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [1:0]  ctrl;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B, C, D;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        ovf_clr;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  demux1x4_reg #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .ctrl     (ctrl),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEMUX1X4_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .ovf      (ovf)
`endif
  );

`ifndef DEMUX1X4_OVF_EN
  assign ovf = 1'b0;
`endif

  // Behavioural model: four mailboxes with a full flag each.
  logic [31:0] md [4];
  logic [3:0]  mf;
  logic        mo;
  wire         m_rdy = !mf[ctrl] || out_ready[ctrl];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) md[k] <= 32'h0;
      mf <= 4'h0;
      mo <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (mf[k] && out_ready[k]) mf[k] <= 1'b0;
      if (in_valid && m_rdy) begin
        md[ctrl] <= in_data;
        mf[ctrl] <= 1'b1;
      end
      if (in_valid && !m_rdy) mo <= 1'b1;
      else if (ovf_clr)       mo <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Continuous comparison against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model out_valid", {28'h0, out_valid}, {28'h0, mf});
      chk("model A", A, md[0]);
      chk("model B", B, md[1]);
      chk("model C", C, md[2]);
      chk("model D", D, md[3]);
      chk("model in_ready", {31'h0, in_ready}, {31'h0, m_rdy});
`ifdef DEMUX1X4_OVF_EN
      chk("model ovf", {31'h0, ovf}, {31'h0, mo});
`endif
    end
  end

  task automatic cyc(input logic v, input logic [1:0] c, input logic [31:0] d, input logic [3:0] r);
    in_valid  = v;
    ctrl      = c;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; ctrl = '0; in_valid = 1'b0; out_ready = '0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset out_valid", {28'h0, out_valid}, 32'h0);
    chk("reset A", A, 32'h0);
    chk("reset D", D, 32'h0);
    chk("reset in_ready", {31'h0, in_ready}, 32'h1);

    // Single load into C
    cyc(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    chk("load C data", C, 32'hDEADBEEF);
    chk("load C out_valid", {28'h0, out_valid}, 32'h4);
    chk("load C A untouched", A, 32'h0);
    chk("load C B untouched", B, 32'h0);

    // Fill all slots, then stall on full B
    pulse_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 2'(k), 32'(k + 1), 4'b0000);
    chk("fill out_valid", {28'h0, out_valid}, 32'hF);
    chk("fill A", A, 32'd1);
    chk("fill B", B, 32'd2);
    chk("fill C", C, 32'd3);
    chk("fill D", D, 32'd4);
    in_valid = 1'b1; ctrl = 2'd1; in_data = 32'd99; out_ready = 4'b0000;
    #1;
    chk("stall in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("stall B held", B, 32'd2);
`ifdef DEMUX1X4_OVF_EN
    chk("ovf set", {31'h0, ovf}, 32'h1);
    ovf_clr = 1'b1;
    cyc(1'b0, 2'd1, 32'd0, 4'b0000);
    ovf_clr = 1'b0;
    chk("ovf cleared", {31'h0, ovf}, 32'h0);
`endif

    // Back-to-back streaming into full slot D
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; ctrl = 2'd3; in_data = 32'(10 + i); out_ready = 4'b1000;
      #1;
      chk("stream in_ready", {31'h0, in_ready}, 32'h1);
      @(posedge clk); #1;
      chk("stream D", D, 32'(10 + i));
      chk("stream valid D", {31'h0, out_valid[3]}, 32'h1);
    end

    // Drain only
    pulse_reset();
    cyc(1'b1, 2'd0, 32'd7, 4'b0000);
    cyc(1'b0, 2'd0, 32'd0, 4'b0001);
    chk("drain valid A", {31'h0, out_valid[0]}, 32'h0);
    chk("drain A holds", A, 32'd7);

    // Accept into A while B drains
    pulse_reset();
    cyc(1'b1, 2'd1, 32'd9, 4'b0000);
    cyc(1'b1, 2'd0, 32'd5, 4'b0010);
    chk("indep out_valid", {28'h0, out_valid}, 32'h1);
    chk("indep A", A, 32'd5);

    // Async reset between edges
    pulse_reset();
    cyc(1'b1, 2'd0, 32'd21, 4'b0000);
    cyc(1'b1, 2'd1, 32'd22, 4'b0000);
    cyc(1'b1, 2'd3, 32'd24, 4'b0000);
    in_valid = 1'b0;
    chk("pre-reset out_valid", {28'h0, out_valid}, 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {28'h0, out_valid}, 32'h0);
    chk("async rst A", A, 32'h0);
    chk("async rst B", B, 32'h0);
    chk("async rst D", D, 32'h0);
    rst = 1'b0;

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      ovf_clr = ($urandom_range(0, 7) == 0);
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
          4'($urandom_range(0, 15)));
    end
    ovf_clr = 1'b0;
    cyc(1'b0, 2'd0, 32'd0, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux1x4_reg.md
Name: demux1x4_reg

Overview:
- Registered 1-to-4 demultiplexer: steers one WIDTH-bit source into one of four single-entry holding slots, selected by a 2-bit code.
- Each slot presents its data to its own consumer with a valid/ready handshake.
- Used in the multi-cycle datapath to route the shared memory/ALU result bus into per-destination latches: IR, MDR, ALUOut and a spare.
- It is the distributing counterpart of the 4-to-1 select muxes, using the same ctrl encoding: 0=A, 1=B, 2=C, 3=D.

Parameters:
- WIDTH, 32, data width of input bus and each slot.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  source data.
- ctrl  input  2  destination select: 0=A, 1=B, 2=C, 3=D.
- in_valid  input  1  source offers in_data this cycle.
- in_ready  output  1  selected slot can accept this cycle.
- A  output  WIDTH  slot A data.
- B  output  WIDTH  slot B data.
- C  output  WIDTH  slot C data.
- D  output  WIDTH  slot D data.
- out_valid  output  4  per-slot valid; bit0=A … bit3=D.
- out_ready  input  4  per-slot consumer ready; bit0=A … bit3=D.

Behaviour:
- Reset:
  - Asynchronous and active-high.
  - A, B, C, D = 0; out_valid = 4'b0000.
  - in_ready = 1 once rst deasserts, because all slots are empty.
- Slot state: each slot k holds data_k and full_k. out_valid[k] = full_k. Data outputs are registered directly, with no combinational path from in_data.
- in_ready is combinational: in_ready = ~full[ctrl] | out_ready[ctrl].
  - It depends only on ctrl, slot state and out_ready; it must not depend on in_valid.
- Accept: accept = in_valid & in_ready. On a rising edge with accept, slot ctrl loads in_data and sets full.
- Latency: data appears on the slot output with out_valid high 1 cycle after accept.
- Drain: for slot k, if out_valid[k] & out_ready[k] and there is no accept into k the same edge, full_k clears.
  - data_k holds its last value; it is not zeroed.
- Simultaneous drain and accept on the same slot (full, out_ready high, in_valid high, ctrl=k):
  - Slot reloads with the new data and full stays 1.
  - This gives full throughput: one word per cycle into a single slot.
- Simultaneous accept into slot j and drain of a different slot k: both take effect independently.
  - Any number of slots may drain on the same edge.
- Full slot with out_ready[k]=0 and ctrl=k: in_ready=0, no state change, and the source must hold its data.
  - Other slots are unaffected. Changing ctrl to an empty slot raises in_ready in the same cycle.
- in_valid=0: no load, regardless of ctrl or in_ready.
- ctrl with X/Z: no requirement. The source must drive ctrl valid whenever in_valid=1.
- Reset asserted mid-transfer: all slots are emptied immediately and outputs return to reset values. Pending data is discarded.

Optional Feature:
- Macro DEMUX1X4_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) and input port ovf_clr (1 bit).
  - ovf is a sticky flag set on any edge where in_valid=1 and in_ready=0, i.e. the source stalled on a full slot.
  - ovf clears on an edge with ovf_clr=1. If set and clear occur on the same edge, set wins.
  - Reset value of ovf is 0.
- Undefined: the ovf and ovf_clr ports and the flag logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, ctrl=2, in_data=32'hDEADBEEF, out_ready=4'b0000 → next cycle C=32'hDEADBEEF, out_valid=4'b0100, A/B/D=0.
- Fill all slots: ctrl=0..3 with data 1, 2, 3, 4 on consecutive cycles, out_ready=0 → out_valid=4'b1111, A..D=1..4. Then ctrl=1, in_valid=1 → in_ready=0, B stays 2.
- Back-to-back streaming into slot D: out_ready[3]=1, ctrl=3, data 10, 11, 12 for three cycles → in_ready stays 1, D shows 10, 11, 12 on successive cycles, out_valid[3] stays high.
- Drain only: slot A full with 7, out_ready=4'b0001, in_valid=0 → next cycle out_valid[0]=0, A remains 7.
- Independent accept/drain: B full, out_ready=4'b0010, accept ctrl=0 data 5 on the same edge → out_valid=4'b0001, A=5.
- Async reset mid-operation: with out_valid=4'b1011, assert rst between clock edges → out_valid=0 and A..D=0 immediately. With DEMUX1X4_OVF_EN defined, a stalled accept sets ovf=1, and ovf_clr=1 clears it to 0 on the next edge.
